// File: rtl/riscv_pkg.sv
// Shared types for the instruction/data memory arbiter.
package riscv_pkg;

    // Which requester currently owns the downstream port
    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2
    } owner_e;

    // Arbiter state: IDLE has nothing outstanding, BUSY waits for mem_ack
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Default number of back-to-back D grants tolerated while I waits
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of fetch, load/store and downstream memory signals around the arbiter.
interface riscv_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic              if_req;
    logic [XLEN-1:0]   if_adr;
    logic              if_ack;
    logic [XLEN-1:0]   if_q;
    logic              if_err;

    logic              d_req;
    logic [XLEN-1:0]   d_adr;
    logic [XLEN-1:0]   d_d;
    logic              d_we;
    logic [XLEN/8-1:0] d_be;
    logic              d_ack;
    logic [XLEN-1:0]   d_q;
    logic              d_misaligned;
    logic              d_page_fault;

    logic              mem_req;
    logic [XLEN-1:0]   mem_adr;
    logic [XLEN-1:0]   mem_d;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_q;
    logic              mem_misaligned;
    logic              mem_page_fault;

    logic              proto_err;

    // Arbiter view
    modport slave (
        input  if_req, if_adr,
        input  d_req, d_adr, d_d, d_we, d_be,
        input  mem_ack, mem_q, mem_misaligned, mem_page_fault,
        output if_ack, if_q, if_err,
        output d_ack, d_q, d_misaligned, d_page_fault,
        output mem_req, mem_adr, mem_d, mem_we, mem_be,
        output proto_err
    );

    // Environment view: requesters plus the memory
    modport master (
        output if_req, if_adr,
        output d_req, d_adr, d_d, d_we, d_be,
        output mem_ack, mem_q, mem_misaligned, mem_page_fault,
        input  if_ack, if_q, if_err,
        input  d_ack, d_q, d_misaligned, d_page_fault,
        input  mem_req, mem_adr, mem_d, mem_we, mem_be,
        input  proto_err
    );

endinterface

// File: rtl/riscv_mem_arbiter_port.sv
// One requester slot: pending flag, latched request fields, protocol-error flag.
// The pending view and field outputs bypass the latch so a request can be
// granted in the very cycle it is pulsed.
module riscv_mem_arbiter_port #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [XLEN-1:0]   adr_i,
    input  logic [XLEN-1:0]   d_i,
    input  logic              we_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic              clr_i,
    output logic              pend_o,
    output logic [XLEN-1:0]   adr_o,
    output logic [XLEN-1:0]   d_o,
    output logic              we_o,
    output logic [XLEN/8-1:0] be_o,
    output logic              proto_err_o
);

    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              lat_en;
    logic [XLEN-1:0]   adr_q;
    logic [XLEN-1:0]   dat_q;
    logic              we_q;
    logic [XLEN/8-1:0] be_q;

    // Set wins over clear; a pulse on a slot still holding an ungranted request is dropped
    always_comb begin
        pend_d = pend_q ? (clr_i ? req_i : 1'b1) : (req_i & ~clr_i);
        err_d  = err_q | (req_i & pend_q & ~clr_i);
        lat_en = req_i & (~pend_q | clr_i);
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Request field latch
    always_ff @(posedge clk) begin
        if (lat_en) begin
            adr_q <= adr_i;
            dat_q <= d_i;
            we_q  <= we_i;
            be_q  <= be_i;
        end
    end

    assign pend_o      = pend_q | req_i;
    assign adr_o       = pend_q ? adr_q : adr_i;
    assign d_o         = pend_q ? dat_q : d_i;
    assign we_o        = pend_q ? we_q  : we_i;
    assign be_o        = pend_q ? be_q  : be_i;
    assign proto_err_o = err_q;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// D has priority; I is forced through after STARVE_MAX consecutive D grants.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic              clk,
    input logic              rst,
    riscv_mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q;
    owner_e            owner_q;
    logic [CW-1:0]     starve_q;
    logic              mem_req_q;
    logic [XLEN-1:0]   mem_adr_q;
    logic [XLEN-1:0]   mem_d_q;
    logic              mem_we_q;
    logic [XLEN/8-1:0] mem_be_q;

    logic              i_pend, d_pend;
    logic [XLEN-1:0]   i_adr, i_d, d_adr, d_d;
    logic              i_we, d_we;
    logic [XLEN/8-1:0] i_be, d_be;
    logic              i_perr, d_perr;
    logic              ack_busy, can_issue, grant_i, grant_d;

    riscv_mem_arbiter_port #(.XLEN(XLEN)) u_port_i (
        .clk        (clk),
        .rst        (rst),
        .req_i      (bus.if_req),
        .adr_i      (bus.if_adr),
        .d_i        ({XLEN{1'b0}}),
        .we_i       (1'b0),
        .be_i       ({(XLEN/8){1'b1}}),
        .clr_i      (grant_i),
        .pend_o     (i_pend),
        .adr_o      (i_adr),
        .d_o        (i_d),
        .we_o       (i_we),
        .be_o       (i_be),
        .proto_err_o(i_perr)
    );

    riscv_mem_arbiter_port #(.XLEN(XLEN)) u_port_d (
        .clk        (clk),
        .rst        (rst),
        .req_i      (bus.d_req),
        .adr_i      (bus.d_adr),
        .d_i        (bus.d_d),
        .we_i       (bus.d_we),
        .be_i       (bus.d_be),
        .clr_i      (grant_d),
        .pend_o     (d_pend),
        .adr_o      (d_adr),
        .d_o        (d_d),
        .we_o       (d_we),
        .be_o       (d_be),
        .proto_err_o(d_perr)
    );

    // Winner selection: issue from IDLE, or straight from BUSY on the ack cycle
    always_comb begin
        ack_busy  = (state_q == ST_BUSY) && bus.mem_ack;
        can_issue = (state_q == ST_IDLE) || ack_busy;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if (can_issue) begin
            if (i_pend && (!d_pend || starve_q == CW'(STARVE_MAX))) begin
                grant_i = 1'b1;
            end else if (d_pend) begin
                grant_d = 1'b1;
            end
        end
    end

    // Arbiter FSM with registered downstream request and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= ARB_NONE;
            starve_q  <= '0;
            mem_req_q <= 1'b0;
            mem_adr_q <= '0;
            mem_d_q   <= '0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
        end else begin
            mem_req_q <= grant_i | grant_d;
            if (grant_i) begin
                state_q   <= ST_BUSY;
                owner_q   <= ARB_IF;
                mem_adr_q <= i_adr;
                mem_d_q   <= i_d;
                mem_we_q  <= i_we;
                mem_be_q  <= i_be;
            end else if (grant_d) begin
                state_q   <= ST_BUSY;
                owner_q   <= ARB_D;
                mem_adr_q <= d_adr;
                mem_d_q   <= d_d;
                mem_we_q  <= d_we;
                mem_be_q  <= d_be;
            end else if (ack_busy) begin
                state_q <= ST_IDLE;
                owner_q <= ARB_NONE;
            end

            if (grant_i || !i_pend) begin
                starve_q <= '0;
            end else if (grant_d && starve_q != CW'(STARVE_MAX)) begin
                starve_q <= starve_q + CW'(1);
            end
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_adr      = mem_adr_q;
    assign bus.mem_d        = mem_d_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_be       = mem_be_q;

    assign bus.if_q         = bus.mem_q;
    assign bus.d_q          = bus.mem_q;
    assign bus.if_ack       = ack_busy && (owner_q == ARB_IF);
    assign bus.d_ack        = ack_busy && (owner_q == ARB_D);
    assign bus.if_err       = bus.if_ack & (bus.mem_misaligned | bus.mem_page_fault);
    assign bus.d_misaligned = bus.d_ack & bus.mem_misaligned;
    assign bus.d_page_fault = bus.d_ack & bus.mem_page_fault;
    assign bus.proto_err    = i_perr | d_perr;

endmodule
